// File: rtl/cache_pkg.sv
// cache_pkg: cache geometry, default line width and the refill FSM state
// encoding shared by the cache refill datapath and its controllers.
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int TAG_W          = 24;
    localparam int IDX_W          = 5;
    localparam int OFF_W          = 3;
    localparam int LINE_W_DEFAULT = 64;

    // Refill sequencing: wait for a miss, wait for memory, write the line.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FILL = 2'd2
    } refill_state_e;

    // Clear the byte-offset bits so the address names a whole line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << OFF_W) - 1);
    endfunction

endpackage

// File: rtl/refill_ctrl.sv
// refill_ctrl: services icache/dcache line misses one at a time.
// The dcache has fixed priority. The winning miss is latched and a line
// request is held to memory until the handshake. The returned line is then
// written to the requesting cache, together with its tag, in a single FILL
// cycle. A request that sees no mem_ready within MAX_WAIT cycles is
// abandoned with a one-cycle err pulse. MAX_WAIT must be at least 1.
module refill_ctrl
    import cache_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int LINE_W   = LINE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              imiss,
    input  logic [31:0]       iaddr,
    input  logic              dmiss,
    input  logic [31:0]       daddr,

    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_data,

    output logic              i_fill,
    output logic              d_fill,
    output logic [IDX_W-1:0]  fill_idx,
    output logic [LINE_W-1:0] fill_data,

    output logic              tag_we_i,
    output logic              tag_we_d,
    output logic [TAG_W-1:0]  tag_wr,

    output logic              i_done,
    output logic              d_done,
    output logic              err
);

    // The counter is at least 8 bits wide and grows for larger MAX_WAIT.
    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    // Last WAIT cycle count value; one more idle cycle here reaches MAX_WAIT.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    refill_state_e     state;
    refill_state_e     state_next;

    logic              src_is_d;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] data_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              err_q;

    logic              accept;
    logic              handshake;
    logic              timeout;

    assign accept    = (state == IDLE) && (dmiss || imiss);
    assign handshake = (state == WAIT) && mem_ready;
    assign timeout   = (state == WAIT) && !mem_ready && (wait_cnt == LAST_WAIT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the handshake is checked before the timeout, so a
    // late mem_ready still completes the refill.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (handshake) begin
                    state_next = FILL;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            FILL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winning miss. The dcache wins ties. Miss inputs are only looked at in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_is_d <= 1'b0;
            addr_q   <= '0;
        end else if (accept) begin
            src_is_d <= dmiss;
            addr_q   <= dmiss ? daddr : iaddr;
        end
    end

    // Capture the returned line on the handshake so it is stable during FILL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (handshake) begin
            data_q <= mem_data;
        end
    end

    // Wait counter: cleared on entry to WAIT, counts WAIT cycles without a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if ((state == WAIT) && !mem_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Abort pulse, raised in the IDLE cycle right after the request is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
        end
    end

    // Output decode: request while waiting, and the source's strobes only in FILL.
    always_comb begin
        mem_req  = 1'b0;
        i_fill   = 1'b0;
        d_fill   = 1'b0;
        tag_we_i = 1'b0;
        tag_we_d = 1'b0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        err      = err_q;
        case (state)
            WAIT: begin
                mem_req = 1'b1;
            end
            FILL: begin
                if (src_is_d) begin
                    d_fill   = 1'b1;
                    tag_we_d = 1'b1;
                    d_done   = 1'b1;
                end else begin
                    i_fill   = 1'b1;
                    tag_we_i = 1'b1;
                    i_done   = 1'b1;
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign mem_addr  = line_align(addr_q);
    assign fill_idx  = addr_q[OFF_W +: IDX_W];
    assign tag_wr    = addr_q[OFF_W + IDX_W +: TAG_W];
    assign fill_data = data_q;

endmodule

// File: doc/refill_ctrl.md
REFILL_CTRL -- requirements
Module: refill_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, max cycles waiting for mem_ready before abort.
REQ-002 SHALL have parameter LINE_W, default 64, refill line width in bits.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports imiss  in  1 and iaddr  in  32: icache miss request and miss address.
REQ-006 SHALL have ports dmiss  in  1 and daddr  in  32: dcache miss request and miss address.
REQ-007 SHALL have ports mem_req  out  1 and mem_addr  out  32: memory line request, address line-aligned (bits [2:0]=0).
REQ-008 SHALL have ports mem_ready  in  1 and mem_data  in  LINE_W: line returned; transfer occurs when mem_req and mem_ready are both high.
REQ-009 SHALL have ports i_fill  out  1, d_fill  out  1, fill_idx  out  5, fill_data  out  LINE_W: one-cycle fill write to icache/dcache.
REQ-010 SHALL have ports tag_we_i  out  1, tag_we_d  out  1, tag_wr  out  24: tag-array update, concurrent with fill.
REQ-011 SHALL have ports i_done  out  1, d_done  out  1, err  out  1: one-cycle completion/abort pulses.

Function
REQ-012 Address split SHALL be tag=[31:8], idx=[7:3], byte offset=[2:0].
REQ-013 FSM SHALL have states IDLE, WAIT, FILL.
REQ-014 In IDLE, dmiss high SHALL win over imiss (fixed dcache priority); the winning address and source SHALL be latched and the FSM SHALL enter WAIT.
REQ-015 mem_req SHALL rise the cycle after the miss is sampled and SHALL stay high, with stable mem_addr, until the handshake cycle or abort.
REQ-016 On handshake, mem_data SHALL be registered, the FSM SHALL enter FILL, and mem_req SHALL drop the next cycle.
REQ-017 FILL SHALL last exactly one cycle: the source's fill strobe, tag_we strobe and done pulse high; fill_idx=latched idx; tag_wr=latched tag; the other source's strobes low.
REQ-018 After FILL the FSM SHALL return to IDLE; a pending miss SHALL be accepted in that IDLE cycle (handshake at cycle k -> FILL k+1 -> IDLE k+2 -> mem_req k+3).
REQ-019 An 8-bit-wide-or-more wait counter SHALL clear on entering WAIT and increment each WAIT cycle without handshake.
REQ-020 When the counter reaches MAX_WAIT without handshake, err SHALL pulse one cycle, mem_req SHALL drop, no fill/done SHALL occur, and the FSM SHALL return to IDLE.
REQ-021 Handshake in the same cycle the counter reaches MAX_WAIT SHALL take precedence over abort.
REQ-022 Deassertion of the miss input during WAIT SHALL NOT cancel the request; the fill and done SHALL still occur.
REQ-023 Miss inputs SHALL be ignored outside IDLE; requesters hold miss until done or err.
REQ-024 All strobes (fills, tag_we, done, err) SHALL be mutually exclusive per source and never high outside FILL except err.

Reset
REQ-025 Reset SHALL asynchronously force IDLE and drive mem_req, i_fill, d_fill, tag_we_i, tag_we_d, i_done, d_done, err low; mem_addr, fill_idx, fill_data, tag_wr to zero; counter to zero.
REQ-026 Reset mid-WAIT or mid-FILL SHALL discard the transaction with no fill or done pulse after reset release.
REQ-027 First miss SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package cache_pkg SHALL hold TAG_W=24, IDX_W=5, OFF_W=3, LINE_W default and the FSM state enum.
REQ-029 Block SHALL be a single module; no sub-module.

Verification
REQ-030 dmiss, daddr=0x0000_1238; mem_ready after 3 cycles, mem_data=0x1122334455667788 -> mem_addr=0x0000_1238&~7=0x0000_1238, d_fill/tag_we_d/d_done one cycle, fill_idx=7, tag_wr=0x000012.
REQ-031 imiss and dmiss same cycle (iaddr=0x400, daddr=0x800) -> dcache serviced first (mem_addr=0x800), then icache (mem_addr=0x400) with mem_req rising 3 cycles after the first handshake.
REQ-032 imiss, mem_ready never asserted, MAX_WAIT=4 -> err pulse after 4 WAIT cycles, no i_fill, mem_req low, IDLE.
REQ-033 MAX_WAIT=4, mem_ready on the 4th WAIT cycle -> fill and done, no err.
REQ-034 reset asserted during WAIT -> all outputs zero immediately; after release no fill/done until a new miss.
REQ-035 imiss dropped one cycle after acceptance -> i_fill and i_done still pulse on handshake.
